// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and sizing helpers.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 1;
  localparam int DEF_STEPS = DEF_WIDTH / DEF_DIGIT;

  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-step build still needs a 1-bit counter.
  function automatic int cnt_width_of(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_add_slice.sv
// Combinational DIGIT-bit adder with carry in/out; one digit of the serial datapath.
module serial_add_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT{1'b0}}, cin_i};

endmodule

// File: rtl/serial_subtractor.sv
// diff = a - b computed as a + ~b + 1, DIGIT bits per cycle LSB first; result valid WIDTH/DIGIT
// cycles after accept and held in DONE until out_ready, in_ready is a pure state decode.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int STEPS = steps_of(WIDTH, DIGIT);
  localparam int CW    = cnt_width_of(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] res_shift;

  serial_add_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i   (ra_q[DIGIT-1:0]),
    .b_i   (rb_q[DIGIT-1:0]),
    .cin_i (carry_q),
    .sum_o (sum),
    .cout_o(cout)
  );

  // New digit enters at the MSB end so the LSB-first stream lands in place after STEPS shifts.
  assign res_shift = (res_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ra_d    = a;
          rb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ra_d    = ra_q >> DIGIT;
        rb_d    = rb_q >> DIGIT;
        res_d   = res_shift;
        carry_d = cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Outputs are captured separately so they keep the last result while the next op runs.
          diff_d   = res_shift;
          borrow_d = ~cout;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule
